uart_tx_serializer: RTL and testbench

//  UART transmit stage sitting directly downstream of the TX seq_mem FIFO. Pops one

---
 rtl/uart_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out as
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx_serializer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               rd_en_q, rd_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               baud_last;

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter logic; outputs are then derived from the next state
  // so that the registered outputs line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    baud_last = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        if (tx_en && !fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = fifo_data;
        par_d   = (^fifo_data) ^ 1'(PARITY_ODD);
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three parameter variants share stimulus, a queue
// models the FIFO, and frames are checked against a bit-time waveform model.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic [2:0] tx_w, rd_w, busy_w, fd_w;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_cyc = 0;
  int fd_cnt = 0;
  int rd_b2b = 0;
  logic rd_prev = 1'b0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty), .fifo_rd_en(rd_w[0]),
    .fifo_data(fifo_data), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
  uart_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty), .fifo_rd_en(rd_w[1]),
    .fifo_data(fifo_data), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
  uart_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty), .fifo_rd_en(rd_w[2]),
    .fifo_data(fifo_data), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

  // FIFO model: data appears the cycle after the read-enable cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_w[0] && q.size() != 0) fifo_data <= q.pop_front();
    fifo_empty <= (q.size() == 0);
  end

  always @(negedge clk) begin
    if (rd_w[0]) begin
      rd_cnt++;
      rd_cyc = cyc;
      if (rd_prev) rd_b2b++;
    end
    rd_prev = rd_w[0];
    if (fd_w[0]) fd_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Line level at cycle c of a frame, counted from the first start-bit cycle.
  function automatic logic exp_tx(input logic [7:0] b, input int pe, input int po, input int c);
    int n = c / CPB;
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    if (pe != 0 && n == 9) return (^b) ^ po[0];
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tx_en = 1'b0;
    q.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic frame_check(input int inst, input logic [7:0] b, input int pe, input int po,
                             input int sb, input bit chk_lat, input int drop_at);
    int len = (1 + 8 + pe + sb) * CPB;
    int w = 0;
    while (tx_w[inst] !== 1'b0 && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (tx_w[inst] !== 1'b0) begin
      bad++;
      $display("FAIL start_timeout inst=%0d got tx=%b want 0", inst, tx_w[inst]);
      return;
    end
    if (chk_lat) begin
      total++;
      if (cyc - rd_cyc != 2) begin
        bad++;
        $display("FAIL start_latency got %0d cycles after rd_en want 2", cyc - rd_cyc);
      end
    end
    for (int c = 0; c < len; c++) begin
      if (c == drop_at) tx_en = 1'b0;
      total++;
      if (tx_w[inst] !== exp_tx(b, pe, po, c) || busy_w[inst] !== 1'b1 || fd_w[inst] !== (c == len - 1)) begin
        bad++;
        $display("FAIL frame inst=%0d byte=%h c=%0d got tx=%b busy=%b fd=%b want tx=%b busy=1 fd=%b",
                 inst, b, c, tx_w[inst], busy_w[inst], fd_w[inst], exp_tx(b, pe, po, c), (c == len - 1));
      end
      if (c != len - 1) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tx_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) q.push_back(8'($urandom));
      tick();
    end
    total++;
    if (tx_w !== 3'b111 || rd_w !== 3'b000 || busy_w !== 3'b000 || fd_w !== 3'b000) begin
      bad++;
      $display("FAIL reset got tx=%b rd=%b busy=%b fd=%b want 111 000 000 000", tx_w, rd_w, busy_w, fd_w);
    end
    do_reset();
  endtask

  task automatic test_single();
    int r0, f0;
    do_reset();
    r0 = rd_cnt;
    f0 = fd_cnt;
    q.push_back(8'hA5);
    tx_en = 1'b1;
    frame_check(0, 8'hA5, 0, 0, 1, 1'b1, -1);
    tick();
    total++;
    if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL single_after got busy=%b tx=%b want busy=0 tx=1", busy_w[0], tx_w[0]);
    end
    repeat (5) tick();
    total++;
    if (rd_cnt - r0 != 1 || fd_cnt - f0 != 1) begin
      bad++;
      $display("FAIL single_counts got rd=%0d fd=%0d want 1 1", rd_cnt - r0, fd_cnt - f0);
    end
    tx_en = 1'b0;
  endtask

  task automatic check_stream(input logic [7:0] bytes[$], input string name);
    int r0, g;
    do_reset();
    r0 = rd_cnt;
    foreach (bytes[i]) q.push_back(bytes[i]);
    tx_en = 1'b1;
    foreach (bytes[i]) begin
      frame_check(0, bytes[i], 0, 0, 1, 1'b1, -1);
      tick();
      if (i != bytes.size() - 1) begin
        g = 0;
        while (tx_w[0] === 1'b1 && g < 20) begin
          g++;
          tick();
        end
        total++;
        if (g != 3) begin
          bad++;
          $display("FAIL %s_gap frame=%0d got %0d mark cycles want 3", name, i, g);
        end
      end
    end
    repeat (5) tick();
    total++;
    if (rd_cnt - r0 != bytes.size() || rd_b2b != 0) begin
      bad++;
      $display("FAIL %s_rd got pulses=%0d consecutive=%0d want %0d 0", name, rd_cnt - r0, rd_b2b, bytes.size());
    end
    tx_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] fixed[$];
    logic [7:0] rnd[$];
    fixed = '{8'h00, 8'hFF};
    check_stream(fixed, "b2b");
    for (int i = 0; i < 5; i++) rnd.push_back(8'($urandom));
    check_stream(rnd, "random");
  endtask

  task automatic test_parity();
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h07 : 8'($urandom);
      do_reset();
      q.push_back(b);
      tx_en = 1'b1;
      fork
        frame_check(1, b, 1, 0, 2, 1'b0, -1);
        frame_check(2, b, 1, 1, 1, 1'b0, -1);
      join
      tx_en = 1'b0;
    end
  endtask

  task automatic test_enable();
    int r0;
    logic [7:0] b1, b2;
    do_reset();
    r0 = rd_cnt;
    tx_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      total++;
      if (rd_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
        bad++;
        $display("FAIL empty_idle i=%0d got rd=%b tx=%b busy=%b want 0 1 0", i, rd_w[0], tx_w[0], busy_w[0]);
      end
    end
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    q.push_back(b1);
    q.push_back(b2);
    frame_check(0, b1, 0, 0, 1, 1'b1, 4 * CPB + 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      total++;
      if (rd_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
        bad++;
        $display("FAIL txen_drop i=%0d got rd=%b tx=%b busy=%b want 0 1 0", i, rd_w[0], tx_w[0], busy_w[0]);
      end
    end
    total++;
    if (rd_cnt - r0 != 1) begin
      bad++;
      $display("FAIL txen_drop_rd got %0d pulses want 1", rd_cnt - r0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int r0, f0, w;
    logic [7:0] b;
    do_reset();
    f0 = fd_cnt;
    q.push_back(8'($urandom));
    tx_en = 1'b1;
    w = 0;
    while (tx_w[0] !== 1'b0 && w < 20) begin
      tick();
      w++;
    end
    repeat (4 * CPB + 1) tick();
    rst = 1'b0;
    tick();
    total++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || fd_w[0] !== 1'b0 || rd_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got tx=%b busy=%b fd=%b rd=%b want 1 0 0 0", tx_w[0], busy_w[0], fd_w[0], rd_w[0]);
    end
    rst = 1'b1;
    r0 = rd_cnt;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_idle i=%0d got tx=%b busy=%b want 1 0", i, tx_w[0], busy_w[0]);
      end
    end
    total++;
    if (rd_cnt != r0 || fd_cnt != f0) begin
      bad++;
      $display("FAIL post_reset_counts got rd=%0d fd=%0d want 0 0", rd_cnt - r0, fd_cnt - f0);
    end
    b = 8'($urandom);
    q.push_back(b);
    frame_check(0, b, 0, 0, 1, 1'b1, -1);
    repeat (5) tick();
    total++;
    if (rd_cnt - r0 != 1) begin
      bad++;
      $display("FAIL post_reset_rd got %0d pulses want 1", rd_cnt - r0);
    end
    tx_en = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_enable();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
